ascon_perm_sched: RTL

Round scheduler for the Ascon permutation. It owns the 320-bit state register, sequences the external single-round datapath (constant addition, substitution layer, linear diffusion layer) once per clock, and runs either p^a (12 rounds) or p^b (6 rounds) per request. It sits between the Ascon mode FSM, which issues permutation requests, and the combinational round logic built from `ascon_pack` types.

---
 rtl/ascon_perm_sched.sv | 82 ++++++++
 1 files changed

// File: rtl/ascon_perm_sched.sv
// ascon_perm_sched: round scheduler for the Ascon permutation.
// Holds the 320-bit state and drives an external single-round datapath
// once per clock, running p^a or p^b rounds per accepted request.
// State words are packed with word0 in bits [63:0] and word4 in bits [319:256].
module ascon_perm_sched #(
  parameter int unsigned NB_ROUNDS_A = 12,
  parameter int unsigned NB_ROUNDS_B = 6
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         rounds_sel_i,
  input  logic [319:0] state_i,
  input  logic [319:0] round_result_i,
  output logic [319:0] perm_state_o,
  output logic [7:0]   round_cst_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  // The last round always has index NB_ROUNDS_A-1; p^b simply starts later.
  localparam logic [3:0] CTR_LAST    = 4'(NB_ROUNDS_A - 1);
  localparam logic [3:0] CTR_START_B = 4'(NB_ROUNDS_A - NB_ROUNDS_B);

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   ctr_q, ctr_d;
  logic [319:0] state_q, state_d;

  // State, round counter and permutation register, synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q   <= S_IDLE;
      ctr_q   <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      ctr_q   <= ctr_d;
      state_q <= state_d;
    end
  end

  // Next-state logic: load on start, commit one round per cycle in RUN.
  always_comb begin
    fsm_d   = fsm_q;
    ctr_d   = ctr_q;
    state_d = state_q;
    unique case (fsm_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = state_i;
          ctr_d   = rounds_sel_i ? CTR_START_B : '0;
          fsm_d   = S_RUN;
        end else if (fsm_q == S_DONE) begin
          fsm_d = S_IDLE;
        end
      end
      S_RUN: begin
        state_d = round_result_i;
        if (ctr_q == CTR_LAST) begin
          fsm_d = S_DONE;
        end else begin
          ctr_d = ctr_q + 4'd1;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  assign perm_state_o = state_q;
  assign round_cst_o  = {4'hF - ctr_q, ctr_q};
  assign busy_o       = (fsm_q == S_RUN);
  assign done_o       = (fsm_q == S_DONE);

endmodule
